// File: rtl/fmap_serializer_pp.sv
// fmap_serializer_pp: ping-pong feature-map buffer with channel-serial readout.
// CH channels of WD-bit activations are captured DEPTH words per frame into one of
// two RAM banks while the other bank is streamed out channel by channel in linear
// or stride-transposed order through a 2-entry output FIFO.
// Optional build macro FMAP_CH_TAG_EN adds o_ch, the channel index of o_tdata.
module fmap_serializer_pp #(
  parameter int unsigned WD     = 3,
  parameter int unsigned CH     = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned STRIDE = 4
) (
  input  logic                     i_sclk,
  input  logic                     i_rstn,
  input  logic                     i_sof,
  input  logic                     i_valid,
  input  logic [CH*WD-1:0]         i_tdata,
  input  logic                     i_mode,
  output logic                     o_in_ready,
  output logic                     o_overflow,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [WD-1:0]            o_tdata,
  output logic                     o_last
`ifdef FMAP_CH_TAG_EN
  ,
  output logic [$clog2(CH)-1:0]    o_ch
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(CH);
  localparam int unsigned R  = DEPTH / STRIDE;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  typedef struct packed {
`ifdef FMAP_CH_TAG_EN
    logic [CW-1:0] ch;
`endif
    logic          last;
    logic [WD-1:0] data;
  } entry_t;

  // Transposed order: (e mod R)*STRIDE + e/R; with powers of two this is pure wiring.
  function automatic logic [AW-1:0] tr_addr(input logic [AW-1:0] e);
    int unsigned ei;
    ei = 32'(e);
    return AW'(((ei % R) * STRIDE) + (ei / R));
  endfunction

  // Write side state
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          wr_bank_q, wr_bank_d;
  logic [1:0]    full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          wr_ready, wr_en, fill;
  logic [AW-1:0] wr_ptr;

  // Read FSM state
  state_e        state_q, state_d;
  logic          rd_bank_q, rd_bank_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [AW-1:0] e_q, e_d;
  logic          issue, frame_done, can_issue;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] iss_ch;
  logic          iss_last;

  // Read pipeline and output FIFO
  logic [CH*WD-1:0] mem_q [2*DEPTH];
  logic [CH*WD-1:0] rd_row_q;
  logic             inf_q, inf_last_q;
  logic [CW-1:0]    inf_ch_q;
  entry_t           head_q, head_d, tail_q, tail_d, push_e;
  logic             h_vld_q, h_vld_d, t_vld_q, t_vld_d;
  logic             pop, push;
  logic [2:0]       occ;

  // Write pointer, bank fill/empty flags and sticky overflow
  always_comb begin
    wr_ready  = ~full_q[wr_bank_q];
    wr_en     = i_valid & wr_ready;
    wr_ptr    = i_sof ? '0 : wr_addr_q;
    fill      = wr_en & ~i_sof & (wr_addr_q == AW'(DEPTH - 1));
    wr_addr_d = wr_addr_q;
    wr_bank_d = wr_bank_q;
    full_d    = full_q;
    ovf_d     = ovf_q | (i_valid & ~wr_ready);
    if (i_sof) begin
      wr_addr_d = wr_en ? AW'(1) : '0;
    end else if (wr_en) begin
      if (fill) begin
        wr_addr_d = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_addr_d = wr_addr_q + AW'(1);
      end
    end
    // Fill and empty always target different banks, so both can land together.
    if (fill)       full_d[wr_bank_q] = 1'b1;
    if (frame_done) full_d[rd_bank_q] = 1'b0;
  end

  // Write side registers
  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_addr_q <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_addr_q <= wr_addr_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
    end
  end

  // Issue a read only if its word is guaranteed a FIFO slot on return
  always_comb begin
    pop       = h_vld_q & i_ready;
    occ       = 3'(h_vld_q) + 3'(t_vld_q) + 3'(inf_q);
    can_issue = occ < (3'd2 + 3'(pop));
  end

  // Read FSM: walk channels (outer) and words (inner) of the full bank
  always_comb begin
    state_d    = state_q;
    rd_bank_d  = rd_bank_q;
    mode_d     = mode_q;
    ch_d       = ch_q;
    e_d        = e_q;
    issue      = 1'b0;
    frame_done = 1'b0;
    rd_addr    = '0;
    iss_ch     = ch_q;
    iss_last   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // First word (ch 0, e 0) issues straight from idle to save a cycle.
        iss_ch = '0;
        if (full_q[rd_bank_q] && can_issue) begin
          issue   = 1'b1;
          mode_d  = i_mode;
          ch_d    = '0;
          e_d     = AW'(1);
          state_d = StRun;
        end
      end
      StRun: begin
        if (can_issue) begin
          issue    = 1'b1;
          rd_addr  = mode_q ? tr_addr(e_q) : e_q;
          iss_last = (ch_q == CW'(CH - 1)) && (e_q == AW'(DEPTH - 1));
          if (e_q == AW'(DEPTH - 1)) begin
            e_d = '0;
            if (ch_q == CW'(CH - 1)) begin
              frame_done = 1'b1;
              rd_bank_d  = ~rd_bank_q;
              state_d    = StIdle;
            end else begin
              ch_d = ch_q + CW'(1);
            end
          end else begin
            e_d = e_q + AW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Read FSM and in-flight read tracking registers
  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= StIdle;
      rd_bank_q  <= 1'b0;
      mode_q     <= 1'b0;
      ch_q       <= '0;
      e_q        <= '0;
      inf_q      <= 1'b0;
      inf_last_q <= 1'b0;
      inf_ch_q   <= '0;
    end else begin
      state_q    <= state_d;
      rd_bank_q  <= rd_bank_d;
      mode_q     <= mode_d;
      ch_q       <= ch_d;
      e_q        <= e_d;
      inf_q      <= issue;
      inf_last_q <= iss_last;
      inf_ch_q   <= iss_ch;
    end
  end

  // Dual-port bank RAM: one write port, one registered read port
  always_ff @(posedge i_sclk) begin
    if (wr_en) mem_q[{wr_bank_q, wr_ptr}] <= i_tdata;
    if (issue) rd_row_q <= mem_q[{rd_bank_q, rd_addr}];
  end

  // Two-entry output FIFO; the head entry drives the outputs directly
  always_comb begin
    push        = inf_q;
    push_e      = '0;
    push_e.data = rd_row_q[inf_ch_q*WD +: WD];
    push_e.last = inf_last_q;
`ifdef FMAP_CH_TAG_EN
    push_e.ch   = inf_ch_q;
`endif
    head_d  = head_q;
    tail_d  = tail_q;
    h_vld_d = h_vld_q;
    t_vld_d = t_vld_q;
    if (pop) begin
      if (t_vld_q) begin
        head_d = tail_q;
        if (push) tail_d = push_e;
        else      t_vld_d = 1'b0;
      end else if (push) begin
        head_d = push_e;
      end else begin
        h_vld_d = 1'b0;
      end
    end else if (push) begin
      if (!h_vld_q) begin
        head_d  = push_e;
        h_vld_d = 1'b1;
      end else begin
        tail_d  = push_e;
        t_vld_d = 1'b1;
      end
    end
  end

  // Output FIFO registers
  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      h_vld_q <= 1'b0;
      t_vld_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      h_vld_q <= h_vld_d;
      t_vld_q <= t_vld_d;
    end
  end

  assign o_in_ready = wr_ready;
  assign o_overflow = ovf_q;
  assign o_valid    = h_vld_q;
  assign o_tdata    = head_q.data;
  assign o_last     = head_q.last;
`ifdef FMAP_CH_TAG_EN
  assign o_ch       = head_q.ch;
`endif

endmodule

// File: doc/fmap_serializer_pp.md
Name: fmap_serializer_pp

Overview:
- Parametrised successor of the 16-channel feature-map buffer.
- Captures CH parallel channels of WD-bit activations, DEPTH words per channel, into ping-pong banks of dual-port RAM.
- Serialises a full bank out channel by channel, in either linear or stride-transposed address order, under valid/ready back-pressure.
- Sits between the parallel quantised conv/pool output and the next serial layer; writes into one bank overlap with readout of the other.

Parameters:
- WD, 3, activation width in bits.
- CH, 16, number of parallel input channels (≥2).
- DEPTH, 16, words per channel per frame (power of 2, ≥4).
- STRIDE, 4, transpose stride (power of 2, divides DEPTH, < DEPTH).

Ports:
- i_sclk  in  1  clock.
- i_rstn  in  1  reset.
- i_sof  in  1  start-of-frame; restarts the write pointer.
- i_valid  in  1  input word valid.
- i_tdata  in  CH*WD  packed channels; channel c occupies bits [c*WD +: WD].
- i_mode  in  1  0 = linear order, 1 = transposed order.
- o_in_ready  out  1  target write bank is free.
- o_overflow  out  1  sticky; a write was dropped.
- o_valid  out  1  output word valid.
- i_ready  in  1  downstream accepts the word.
- o_tdata  out  WD  output word.
- o_last  out  1  last word of the frame (word CH*DEPTH-1).
- Interface rule: one clock; reset is asynchronous and active-low (i_sclk, i_rstn).

Behaviour:
- Reset: all counters 0, both banks empty, wr_bank=0, rd_bank=0, FSM in IDLE.
- Outputs at reset: o_valid=0, o_tdata=0, o_last=0, o_overflow=0, o_in_ready=1.
- Write side:
  - Accepted write = i_valid && o_in_ready. It stores i_tdata at wr_addr in bank wr_bank, and wr_addr increments.
  - Write with wr_addr==DEPTH-1: that bank is marked full, wr_bank toggles, wr_addr goes to 0.
  - i_valid while !o_in_ready: data dropped, o_overflow set to 1 and held until reset.
  - i_sof: wr_addr goes to 0 and the partial frame is discarded. If i_valid is also high, the word is written at address 0 and wr_addr goes to 1.
- Read FSM, IDLE → RUN:
  - Leaves IDLE when bank rd_bank is full; i_mode is latched at that point.
  - RUN walks ch = 0..CH-1 in the outer loop and e = 0..DEPTH-1 in the inner loop.
  - Linear address = e.
  - Transposed address = (e mod R)*STRIDE + e/R, where R = DEPTH/STRIDE. For 16/4 the order is 0,4,8,12,1,5,9,13,2,…,15.
  - After the last read is issued: the bank is marked empty, rd_bank toggles, and the FSM returns to IDLE.
  - Back-to-back: if the other bank is already full, the FSM re-enters RUN on the next cycle.
- Read datapath:
  - RAM read latency is 1 cycle.
  - Output is a 2-entry FIFO; a read issues only when occupancy + inflight − pop < 2.
  - o_tdata/o_valid/o_last are registered, driven from the FIFO head.
- Timing:
  - o_valid first rises 2 edges after the edge capturing the last write.
  - With i_ready held high: 1 word/cycle, CH*DEPTH consecutive words per frame.
- Handshake:
  - Output held stable while o_valid && !i_ready.
  - No word lost or duplicated under arbitrary i_ready toggling.
- Same-cycle write-fill and read-empty of different banks are both honoured.
- Reset mid-frame discards everything.

Optional Feature:
- Macro: FMAP_CH_TAG_EN.
- Defined: adds output port o_ch [$clog2(CH)-1:0], the channel index of the current o_tdata. It is carried through the FIFO alongside the data and resets to 0.
- Undefined: port absent, no extra logic.

Test Plan (all with WD=3, CH=16, DEPTH=16, STRIDE=4):
- Linear readout:
  - Stimulus: i_mode=0; 16 writes with channel c, word k = (c+k) mod 8; i_ready=1.
  - Response: 256 words, word n = (n/16 + n mod 16) mod 8; o_last only on word 255; first o_valid 2 cycles after the last write.
- Transposed readout:
  - Stimulus: i_mode=1; channel 0 written 0..7,0..7.
  - Response: first 16 outputs are 0,4,0,4,1,5,1,5,2,6,2,6,3,7,3,7.
- Ping-pong and overflow:
  - Stimulus: 3 frames written back-to-back with i_ready=0.
  - Response: first two frames accepted; o_in_ready=0 after 32 writes; third frame dropped, o_overflow=1. Releasing i_ready yields 512 words, frames 1 then 2.
- Back-pressure:
  - Stimulus: i_ready random at 50%.
  - Response: output sequence identical to the linear-readout case; o_tdata stable while stalled.
- Resync:
  - Stimulus: i_sof after 7 writes, then 16 writes.
  - Response: only the 16 post-sof words are read out.
- Reset:
  - Stimulus: i_rstn low mid-readout.
  - Response: o_valid=0 immediately (asynchronous); o_overflow=0; the next full frame reads out correctly.
